// File: rtl/parser_pkt_dispatch_rr_if.sv
// Signal bundle for parser_pkt_dispatch_rr: AXIS ingress, per-queue egress, PHV in/out and tag status.
// slave is the dispatcher's view, master is the surrounding logic's view.
interface parser_pkt_dispatch_rr_if #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_NUM_QUEUES         = 4,
  parameter int unsigned C_TAG_FIFO_DEPTH     = 8,
  parameter int unsigned PKT_HDR_LEN          = 1024
);
  localparam int unsigned DW   = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned UW   = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned KW   = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned N    = C_NUM_QUEUES;
  localparam int unsigned CNTW = $clog2(C_TAG_FIFO_DEPTH) + 1;

  logic [DW-1:0]          s_axis_tdata;
  logic [UW-1:0]          s_axis_tuser;
  logic [KW-1:0]          s_axis_tkeep;
  logic                   s_axis_tvalid;
  logic                   s_axis_tlast;
  logic                   s_axis_tready;
  logic [N*DW-1:0]        m_axis_tdata;
  logic [N*UW-1:0]        m_axis_tuser;
  logic [N*KW-1:0]        m_axis_tkeep;
  logic [N-1:0]           m_axis_tlast;
  logic [N-1:0]           m_axis_tvalid;
  logic [N-1:0]           m_axis_tready;
  logic                   phv_in_valid;
  logic [PKT_HDR_LEN-1:0] phv_in;
  logic                   phv_out_valid;
  logic [PKT_HDR_LEN-1:0] phv_out;
  logic                   tag_err;
  logic [CNTW-1:0]        tag_fifo_cnt;

  modport slave (
    input  s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready,
    input  phv_in_valid, phv_in,
    output phv_out_valid, phv_out, tag_err, tag_fifo_cnt
  );

  modport master (
    output s_axis_tdata, s_axis_tuser, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready,
    output phv_in_valid, phv_in,
    input  phv_out_valid, phv_out, tag_err, tag_fifo_cnt
  );
endinterface

// File: rtl/parser_pkt_dispatch_rr.sv
// Packet-atomic round-robin dispatcher; a tag FIFO pairs each packet's queue with its PHV.
// Optional PARSER_DISPATCH_SKIP_FULL_EN: packet starts skip to the next ready queue.
module parser_pkt_dispatch_rr #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_NUM_QUEUES         = 4,
  parameter int unsigned C_TAG_FIFO_DEPTH     = 8,
  parameter int unsigned PKT_HDR_LEN          = 1024,
  parameter int unsigned C_TAG_OFFSET         = 141
) (
  input  logic axis_clk,
  input  logic areset,
  parser_pkt_dispatch_rr_if.slave bus
);
  localparam int unsigned N    = C_NUM_QUEUES;
  localparam int unsigned D    = C_TAG_FIFO_DEPTH;
  localparam int unsigned AW   = $clog2(D);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned QW   = $clog2(N);

  typedef enum logic {IDLE, BODY} state_t;

  state_t           state, state_nxt;
  logic [QW-1:0]    cur, cur_nxt, sel, sel_nxt, tgt, route;
  logic             gate, ready_c, accept, push, pop, tag_full, tag_empty;
  logic [N-1:0]     valid_vec, push_tag;
  logic [N-1:0]     tag_mem [D];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNTW-1:0]  cnt;
  logic [PKT_HDR_LEN-1:0] phv_tagged, phv_out_q;
  logic             phv_out_valid_q, tag_err_q;

  function automatic logic [QW-1:0] inc_q(input logic [QW-1:0] q);
    return (q == QW'(N - 1)) ? '0 : q + QW'(1);
  endfunction

  // Target queue for the next packet start
`ifdef PARSER_DISPATCH_SKIP_FULL_EN
  logic          found;
  int unsigned   j;
  logic [QW-1:0] idx;
  always_comb begin
    tgt   = cur;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(cur) + i;
      if (j >= N) j = j - N;
      idx = QW'(j);
      if (!found && bus.m_axis_tready[idx]) begin
        tgt   = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb tgt = cur;
`endif

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      state <= IDLE;
      cur   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      sel   <= sel_nxt;
    end
  end

  // Packet FSM: starts are gated by tag space, body beats are never gated
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    sel_nxt   = sel;
    push      = 1'b0;
    route     = sel;
    gate      = 1'b1;
    if (state == IDLE) begin
      route = tgt;
      gate  = !tag_full;
    end
    ready_c          = bus.m_axis_tready[route] & gate & !areset;
    valid_vec        = '0;
    valid_vec[route] = bus.s_axis_tvalid & gate & !areset;
    accept           = bus.s_axis_tvalid & ready_c;
    if (accept) begin
      case (state)
        IDLE: begin
          push    = 1'b1;
          sel_nxt = tgt;
          if (bus.s_axis_tlast) cur_nxt = inc_q(tgt);
          else                  state_nxt = BODY;
        end
        BODY: begin
          if (bus.s_axis_tlast) begin
            cur_nxt   = inc_q(sel);
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.s_axis_tready = ready_c;
  assign bus.m_axis_tvalid = valid_vec;
  assign bus.m_axis_tdata  = {N{bus.s_axis_tdata}};
  assign bus.m_axis_tuser  = {N{bus.s_axis_tuser}};
  assign bus.m_axis_tkeep  = {N{bus.s_axis_tkeep}};
  assign bus.m_axis_tlast  = {N{bus.s_axis_tlast}};

  // Tag FIFO of one-hot queue IDs in packet arrival order
  assign tag_full  = (cnt == CNTW'(D));
  assign tag_empty = (cnt == '0);
  assign pop       = bus.phv_in_valid & !tag_empty;
  assign push_tag  = N'(1) << tgt;

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge axis_clk) begin
    if (push) tag_mem[wr_ptr] <= push_tag;
  end

  // PHV tagging: an empty FIFO yields a zero field and latches the error
  always_comb begin
    phv_tagged = bus.phv_in;
    phv_tagged[C_TAG_OFFSET +: N] = tag_empty ? '0 : tag_mem[rd_ptr];
  end

  always_ff @(posedge axis_clk) begin
    if (areset) begin
      phv_out_valid_q <= 1'b0;
      phv_out_q       <= '0;
      tag_err_q       <= 1'b0;
    end else begin
      phv_out_valid_q <= bus.phv_in_valid;
      if (bus.phv_in_valid)             phv_out_q <= phv_tagged;
      if (bus.phv_in_valid & tag_empty) tag_err_q <= 1'b1;
    end
  end

  assign bus.phv_out_valid = phv_out_valid_q;
  assign bus.phv_out       = phv_out_q;
  assign bus.tag_err       = tag_err_q;
  assign bus.tag_fifo_cnt  = cnt;
endmodule

// File: tb/tb_parser_pkt_dispatch_rr.sv
// Self-checking bench for parser_pkt_dispatch_rr: a reference model of routing and tag FIFO feeds
// a PHV scoreboard; directed sequences check dispatch order against fixed tables.
module tb_parser_pkt_dispatch_rr;
  localparam int unsigned DW   = 256;
  localparam int unsigned UW   = 128;
  localparam int unsigned N    = 4;
  localparam int unsigned D    = 8;
  localparam int unsigned HDR  = 1024;
  localparam int unsigned OFF  = 141;
  localparam int unsigned CW   = 1024;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  parser_pkt_dispatch_rr_if #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .C_NUM_QUEUES(N),
    .C_TAG_FIFO_DEPTH(D), .PKT_HDR_LEN(HDR)
  ) bus ();

  parser_pkt_dispatch_rr #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .C_NUM_QUEUES(N),
    .C_TAG_FIFO_DEPTH(D), .PKT_HDR_LEN(HDR), .C_TAG_OFFSET(OFF)
  ) dut (
    .axis_clk(clk),
    .areset  (areset),
    .bus     (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [N-1:0]   m_fifo [$];
  logic [HDR-1:0] phv_sb [$];
  int             order_log [$];
  int             exp_q [$];
  int unsigned    m_cur = 0, m_sel = 0, m_tg = 0;
  bit             m_body = 0, m_err = 0, m_phv_v = 0, obs_in_pkt = 0;
  bit             m_gate, m_exp_r, m_acc;
  logic [N-1:0]   m_exp_v, m_tag;
  logic [HDR-1:0] m_phv;
  bit             pkts_done;

  function automatic int unsigned m_tgt();
`ifdef PARSER_DISPATCH_SKIP_FULL_EN
    for (int unsigned i = 0; i < N; i++)
      if (bus.m_axis_tready[(m_cur + i) % N]) return (m_cur + i) % N;
`endif
    return m_cur;
  endfunction

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 99;
  endfunction

  // Monitor: compare outputs against the model, then advance the model for the coming edge
  always @(negedge clk) begin
    chk("phv_out_valid", CW'(bus.phv_out_valid), CW'(m_phv_v));
    chk("tag_err", CW'(bus.tag_err), CW'(m_err));
    chk("tag_fifo_cnt", CW'(bus.tag_fifo_cnt), CW'(m_fifo.size()));
    if (bus.phv_out_valid === 1'b1) begin
      chk("phv_sb_nonempty", CW'(phv_sb.size() != 0), CW'(1));
      if (phv_sb.size() != 0) begin
        m_phv = phv_sb.pop_front();
        chk("phv_out", CW'(bus.phv_out), CW'(m_phv));
      end
    end
    if (areset) begin
      chk("rst_s_axis_tready", CW'(bus.s_axis_tready), CW'(0));
      chk("rst_m_axis_tvalid", CW'(bus.m_axis_tvalid), CW'(0));
      m_fifo.delete();
      phv_sb.delete();
      m_cur = 0; m_sel = 0; m_body = 0; m_err = 0; m_phv_v = 0; obs_in_pkt = 0;
    end else begin
      if (!m_body) begin
        m_tg   = m_tgt();
        m_gate = (m_fifo.size() < D);
      end else begin
        m_tg   = m_sel;
        m_gate = 1'b1;
      end
      m_exp_r = bus.m_axis_tready[m_tg] & m_gate;
      m_exp_v = (bus.s_axis_tvalid & m_gate) ? (N'(1) << m_tg) : '0;
      chk("s_axis_tready", CW'(bus.s_axis_tready), CW'(m_exp_r));
      chk("m_axis_tvalid", CW'(bus.m_axis_tvalid), CW'(m_exp_v));
      m_acc = bus.s_axis_tvalid & m_exp_r;
      if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        chk("m_axis_tdata", CW'(bus.m_axis_tdata[m_tg*DW +: DW]), CW'(bus.s_axis_tdata));
        chk("m_axis_tuser", CW'(bus.m_axis_tuser[m_tg*UW +: UW]), CW'(bus.s_axis_tuser));
        chk("m_axis_tkeep", CW'(bus.m_axis_tkeep[m_tg*(DW/8) +: DW/8]), CW'(bus.s_axis_tkeep));
        chk("m_axis_tlast", CW'(bus.m_axis_tlast[m_tg]), CW'(bus.s_axis_tlast));
        if (!obs_in_pkt) order_log.push_back(oh2idx(bus.m_axis_tvalid));
        obs_in_pkt = !bus.s_axis_tlast;
      end
      if (bus.phv_in_valid) begin
        m_tag = '0;
        if (m_fifo.size() > 0) m_tag = m_fifo.pop_front();
        else                   m_err = 1'b1;
        m_phv = bus.phv_in;
        m_phv[OFF +: N] = m_tag;
        phv_sb.push_back(m_phv);
      end
      m_phv_v = bus.phv_in_valid;
      if (m_acc) begin
        if (!m_body) begin
          m_fifo.push_back(N'(1) << m_tg);
          m_sel = m_tg;
          if (bus.s_axis_tlast) m_cur = (m_tg + 1) % N;
          else                  m_body = 1'b1;
        end else if (bus.s_axis_tlast) begin
          m_cur  = (m_sel + 1) % N;
          m_body = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input bit last);
    bit done = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = last;
    bus.s_axis_tdata  = {8{$urandom}};
    bus.s_axis_tuser  = {4{$urandom}};
    bus.s_axis_tkeep  = $urandom;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      done = bus.s_axis_tready;
      tick();
    end
    chk("beat_accept_in_budget", CW'(done), CW'(1));
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int unsigned len);
    for (int unsigned b = 0; b < len; b++) send_beat(b == len - 1);
  endtask

  task automatic phv_pulse();
    bus.phv_in_valid = 1'b1;
    bus.phv_in       = {32{$urandom}};
    tick();
    bus.phv_in_valid = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    order_log.delete();
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_len"}, CW'(order_log.size()), CW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < order_log.size(); i++)
      chk(tag, CW'(order_log[i]), CW'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset            = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tuser  = '0;
    bus.s_axis_tkeep  = '0;
    bus.m_axis_tready = '1;
    bus.phv_in_valid  = 1'b0;
    bus.phv_in        = '0;
    repeat (3) tick();
    chk("rst_phv_out", CW'(bus.phv_out), CW'(0));
    chk("rst_cnt", CW'(bus.tag_fifo_cnt), CW'(0));
    areset = 1'b0;
    order_log.delete();

    // Single-beat packets rotate through all queues; PHVs carry the matching tags
    for (int i = 0; i < 8; i++) send_pkt(1);
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_order("t1_order");
    chk("t1_cnt", CW'(bus.tag_fifo_cnt), CW'(8));
    for (int i = 0; i < 8; i++) begin
      phv_pulse();
      chk("t1_tag", CW'(bus.phv_out[OFF +: N]), CW'(N'(1) << (i % N)));
    end
    tick();

    // Mid-packet stall stays on the packet's queue
    do_reset();
    send_beat(1'b0);
    bus.m_axis_tready[0] = 1'b0;
    bus.s_axis_tvalid    = 1'b1;
    bus.s_axis_tlast     = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t2_stall_tready", CW'(bus.s_axis_tready), CW'(0));
      tick();
    end
    bus.m_axis_tready[0] = 1'b1;
    send_beat(1'b0);
    send_beat(1'b1);
    send_pkt(1);
    exp_q = '{0, 1};
    check_order("t2_order");

    // Start target not ready while other queues are
    do_reset();
`ifdef PARSER_DISPATCH_SKIP_FULL_EN
    bus.m_axis_tready[1] = 1'b0;
    for (int i = 0; i < 4; i++) send_pkt(1);
    bus.m_axis_tready[1] = 1'b1;
    for (int i = 0; i < 2; i++) send_pkt(1);
    exp_q = '{0, 2, 3, 0, 1, 2};
`else
    fork
      begin
        bus.m_axis_tready[1] = 1'b0;
        repeat (20) tick();
        bus.m_axis_tready[1] = 1'b1;
      end
      begin
        for (int i = 0; i < 6; i++) send_pkt(1);
      end
    join
    exp_q = '{0, 1, 2, 3, 0, 1};
`endif
    check_order("t3_order");
    for (int i = 0; i < 6; i++) begin
      phv_pulse();
      chk("t3_tag", CW'(bus.phv_out[OFF +: N]), CW'(N'(1) << exp_q[i]));
    end
    tick();

    // Full tag FIFO blocks the next start until a PHV pops
    do_reset();
    for (int i = 0; i < 8; i++) send_pkt(1);
    chk("t4_cnt_full", CW'(bus.tag_fifo_cnt), CW'(8));
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tlast  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_blocked", CW'(bus.s_axis_tready), CW'(0));
      tick();
    end
    bus.phv_in_valid = 1'b1;
    bus.phv_in       = {32{$urandom}};
    @(negedge clk);
    chk("t4_blocked_pop_cycle", CW'(bus.s_axis_tready), CW'(0));
    tick();
    bus.phv_in_valid = 1'b0;
    @(negedge clk);
    chk("t4_accept_after_pop", CW'(bus.s_axis_tready), CW'(1));
    tick();
    bus.s_axis_tvalid = 1'b0;
    chk("t4_cnt_refull", CW'(bus.tag_fifo_cnt), CW'(8));
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    check_order("t4_order");
    for (int i = 0; i < 8; i++) phv_pulse();
    tick();

    // PHV with empty FIFO (including empty-with-push) and reset clearing tag_err and cur
    do_reset();
    fork
      send_pkt(1);
      phv_pulse();
    join
    chk("t5_tag_zero", CW'(bus.phv_out[OFF +: N]), CW'(0));
    chk("t5_err_set", CW'(bus.tag_err), CW'(1));
    chk("t5_cnt_after_push", CW'(bus.tag_fifo_cnt), CW'(1));
    send_pkt(1);
    repeat (4) tick();
    chk("t5_err_sticky", CW'(bus.tag_err), CW'(1));
    do_reset();
    chk("t5_err_cleared", CW'(bus.tag_err), CW'(0));
    send_pkt(1);
    exp_q = '{0};
    check_order("t5_cur_reset");
    phv_pulse();
    tick();

    // Simultaneous push and pop, then random traffic against the model
    do_reset();
    for (int i = 0; i < 7; i++) send_pkt(1);
    fork
      send_pkt(1);
      phv_pulse();
    join
    chk("t6_cnt_pushpop", CW'(bus.tag_fifo_cnt), CW'(7));
    for (int i = 0; i < 7; i++) phv_pulse();
    tick();
    order_log.delete();
    pkts_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 100; p++) send_pkt($urandom_range(1, 3));
        pkts_done = 1'b1;
      end
      begin
        while (!pkts_done) begin
          for (int q = 0; q < N; q++) bus.m_axis_tready[q] = ($urandom_range(0, 3) != 0);
          tick();
        end
        bus.m_axis_tready = '1;
      end
      begin
        while (!pkts_done) begin
          bus.phv_in_valid = (m_fifo.size() > 0) && ($urandom_range(0, 2) == 0);
          bus.phv_in       = {32{$urandom}};
          tick();
        end
        bus.phv_in_valid = 1'b0;
      end
    join
    for (int i = 0; i < 2 * D && m_fifo.size() > 0; i++) phv_pulse();
    repeat (2) tick();
    chk("t6_pkts", CW'(order_log.size()), CW'(100));
    chk("t6_cnt_drained", CW'(bus.tag_fifo_cnt), CW'(0));
    chk("t6_no_err", CW'(bus.tag_err), CW'(0));
    chk("t6_sb_drained", CW'(phv_sb.size()), CW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
